// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered arithmetic unit between two ports.
// Operands are latched at grant; the result returns to the owner ALU_LAT+1 edges later with a one-cycle ack.
module alu_req_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [3:0] sel0,
    input  logic [3:0] sel1,
    input  logic       cin0,
    input  logic       cin1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    output logic       alu_c_in,
    input  logic [7:0] alu_c_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] res0_q, res0_d;
    logic [7:0] res1_q, res1_d;
    logic       busy_q, busy_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic       alu_c_in_q, alu_c_in_d;

    logic       grant;
    logic       winner;
    logic [7:0] win_a;
    logic [7:0] win_b;
    logic [3:0] win_sel;
    logic       win_cin;

    always_comb begin
        grant   = req0 | req1;
        // On a tie the port that was not served most recently wins.
        winner  = (req0 & req1) ? ~last_q : req1;
        win_a   = winner ? a1   : a0;
        win_b   = winner ? b1   : b0;
        win_sel = winner ? sel1 : sel0;
        win_cin = winner ? cin1 : cin0;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        res0_d     = res0_q;
        res1_d     = res1_q;
        busy_d     = busy_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        alu_c_in_d = alu_c_in_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (grant) begin
                    alu_a_d    = win_a;
                    alu_b_d    = win_b;
                    alu_sel_d  = win_sel;
                    alu_c_in_d = win_cin;
                    owner_d    = winner;
                    last_d     = winner;
                    cnt_d      = LAT_CNT;
                    busy_d     = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (owner_q) begin
                        res1_d = alu_c_out;
                        ack1_d = 1'b1;
                    end else begin
                        res0_d = alu_c_out;
                        ack0_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Return to IDLE without arbitrating; a held req is seen on the following edge.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            res0_q     <= 8'd0;
            res1_q     <= 8'd0;
            busy_q     <= 1'b0;
            alu_a_q    <= 8'd0;
            alu_b_q    <= 8'd0;
            alu_sel_q  <= 4'd0;
            alu_c_in_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            busy_q     <= busy_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            alu_c_in_q <= alu_c_in_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign res0     = res0_q;
    assign res1     = res1_q;
    assign busy     = busy_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign alu_c_in = alu_c_in_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: ALU_LAT=1 and ALU_LAT=4 instances, each with a registered ALU model.
module tb_alu_req_arbiter;

    logic       clk;
    logic       rst_n;

    logic       req0, req1, cin0, cin1;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] sel0, sel1;
    logic       ack0, ack1, busy, alu_c_in;
    logic [7:0] res0, res1, alu_a, alu_b, alu_c_out;
    logic [3:0] alu_sel;

    logic       q_req0, q_req1, q_cin0, q_cin1;
    logic [7:0] q_a0, q_b0, q_a1, q_b1;
    logic [3:0] q_sel0, q_sel1;
    logic       q_ack0, q_ack1, q_busy, q_alu_c_in;
    logic [7:0] q_res0, q_res1, q_alu_a, q_alu_b, q_alu_c_out;
    logic [3:0] q_alu_sel;
    logic [7:0] pipe4 [4];

    typedef struct {
        logic       port;
        logic [7:0] res;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    alu_req_arbiter #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sel0(sel0), .sel1(sel1), .cin0(cin0), .cin1(cin1),
        .ack0(ack0), .ack1(ack1), .res0(res0), .res1(res1), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c_in(alu_c_in),
        .alu_c_out(alu_c_out)
    );

    alu_req_arbiter #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(q_req0), .req1(q_req1),
        .a0(q_a0), .b0(q_b0), .a1(q_a1), .b1(q_b1),
        .sel0(q_sel0), .sel1(q_sel1), .cin0(q_cin0), .cin1(q_cin1),
        .ack0(q_ack0), .ack1(q_ack1), .res0(q_res0), .res1(q_res1), .busy(q_busy),
        .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_sel(q_alu_sel), .alu_c_in(q_alu_c_in),
        .alu_c_out(q_alu_c_out)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic ci);
        case (s)
            4'd0:    return a + b + {7'd0, ci};
            4'd1:    return a - b;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) alu_c_out <= alu_fn(alu_a, alu_b, alu_sel, alu_c_in);

    always @(posedge clk) begin
        pipe4[0] <= alu_fn(q_alu_a, q_alu_b, q_alu_sel, q_alu_c_in);
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign q_alu_c_out = pipe4[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Waits for the ack of 'port' on dut; exp_n is the number of negedges from the call.
    task automatic wait_ack(input string tag, input logic port, input int exp_n, input bit drop);
        int   k;
        bit   got;
        bit   other;
        exp_t e;
        k = 0; got = 0; other = 0;
        while (!got && k < 24) begin
            @(negedge clk);
            k++;
            if ((port ? ack0 : ack1) === 1'b1) other = 1;
            if ((port ? ack1 : ack0) === 1'b1) got = 1;
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_ack_delay"}, 32'(k), 32'(exp_n));
        check({tag, "_other_ack_quiet"}, 32'(other), 32'd0);
        check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_port"}, 32'(port), 32'(e.port));
            check({tag, "_res"}, 32'(port ? res1 : res0), 32'(e.res));
        end
        if (got && drop) begin
            if (port) req1 = 1'b0;
            else req0 = 1'b0;
        end
    endtask

    initial begin
        int   k4;
        int   busy_cnt;
        int   ack_cnt;
        bit   got4;
        bit   other4;
        exp_t e4;

        rst_n = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        sel0 = 0; sel1 = 0; cin0 = 0; cin1 = 0;
        q_req0 = 0; q_req1 = 0; q_a0 = 0; q_b0 = 0; q_a1 = 0; q_b1 = 0;
        q_sel0 = 0; q_sel1 = 0; q_cin0 = 0; q_cin1 = 0;

        repeat (2) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_res0", 32'(res0), 32'd0);
        check("rst_res1", 32'(res1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", {alu_a, alu_b, alu_sel, 3'd0, alu_c_in, 8'd0}, 32'd0);
        check("rst_busy4", 32'(q_busy), 32'd0);
        check("rst_res4", {16'd0, q_res0, q_res1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Single request from port 0
        req0 = 1; a0 = 8'd2; b0 = 8'd3; sel0 = 4'd0; cin0 = 1'b1;
        sb.push_back('{1'b0, 8'd6});
        @(negedge clk);
        check("single_alu_a", 32'(alu_a), 32'd2);
        check("single_alu_b", 32'(alu_b), 32'd3);
        check("single_alu_cin", 32'(alu_c_in), 32'd1);
        check("single_busy_rise", 32'(busy), 32'd1);
        check("single_no_early_ack", 32'(ack0), 32'd0);
        wait_ack("single", 1'b0, 2, 1'b1);
        @(negedge clk);
        check("single_ack_one_cycle", 32'(ack0), 32'd0);
        check("single_busy_fall", 32'(busy), 32'd0);

        // Simultaneous requests right after reset, then alternation
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; a0 = 8'd2; b0 = 8'd3; sel0 = 4'd0; cin0 = 1'b0;
        req1 = 1; a1 = 8'd9; b1 = 8'd4; sel1 = 4'd1; cin1 = 1'b0;
        sb.push_back('{1'b0, 8'd5});
        sb.push_back('{1'b1, 8'd5});
        wait_ack("tie_p0", 1'b0, 3, 1'b1);
        wait_ack("tie_p1", 1'b1, 4, 1'b0);
        req0 = 1; a0 = 8'd3; b0 = 8'd4; sel0 = 4'd0; cin0 = 1'b0;
        a1 = 8'd5; b1 = 8'd2; sel1 = 4'd1;
        sb.push_back('{1'b0, 8'd7});
        sb.push_back('{1'b1, 8'd3});
        wait_ack("alt_p0", 1'b0, 4, 1'b1);
        wait_ack("alt_p1", 1'b1, 4, 1'b1);
        @(negedge clk);
        check("alt_ack1_one_cycle", 32'(ack1), 32'd0);
        check("alt_busy_fall", 32'(busy), 32'd0);

        // Back-to-back from port 0 with req held
        req0 = 1; a0 = 8'd1; b0 = 8'd1; sel0 = 4'd0; cin0 = 1'b0;
        sb.push_back('{1'b0, 8'd2});
        sb.push_back('{1'b0, 8'd3});
        sb.push_back('{1'b0, 8'd4});
        wait_ack("b2b_1", 1'b0, 3, 1'b0);
        a0 = 8'd2;
        wait_ack("b2b_2", 1'b0, 4, 1'b0);
        a0 = 8'd3;
        wait_ack("b2b_3", 1'b0, 4, 1'b1);
        @(negedge clk);
        check("b2b_busy_fall", 32'(busy), 32'd0);

        // Operands are sampled only at grant
        req0 = 1; a0 = 8'd2; b0 = 8'd3; sel0 = 4'd0; cin0 = 1'b0;
        sb.push_back('{1'b0, 8'd5});
        @(negedge clk);
        check("stable_alu_a", 32'(alu_a), 32'd2);
        a0 = 8'd7;
        wait_ack("stable", 1'b0, 2, 1'b1);
        @(negedge clk);

        // Reset in WAIT aborts without an ack; pending req1 is granted on the first IDLE edge
        req0 = 1; a0 = 8'd8; b0 = 8'd8; sel0 = 4'd0; cin0 = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        req1 = 1; a1 = 8'd9; b1 = 8'd4; sel1 = 4'd1; cin1 = 1'b0;
        sb.push_back('{1'b1, 8'd5});
        #2 rst_n = 1'b0;
        #1;
        check("abort_ack0", 32'(ack0), 32'd0);
        check("abort_res0", 32'(res0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("abort_ack0_held", 32'(ack0), 32'd0);
        rst_n = 1'b1;
        wait_ack("after_abort", 1'b1, 3, 1'b1);
        @(negedge clk);

        // ALU_LAT = 4 instance
        q_req1 = 1; q_a1 = 8'd10; q_b1 = 8'd3; q_sel1 = 4'd1; q_cin1 = 1'b0;
        sb.push_back('{1'b1, 8'd7});
        k4 = 0; busy_cnt = 0; ack_cnt = 0; got4 = 0; other4 = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (q_busy === 1'b1) busy_cnt++;
            if (q_ack0 === 1'b1) other4 = 1;
            if (q_ack1 === 1'b1) begin
                ack_cnt++;
                if (!got4) begin
                    got4 = 1;
                    k4 = n;
                    q_req1 = 1'b0;
                    check("lat4_sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e4 = sb.pop_front();
                        check("lat4_res1", 32'(q_res1), 32'(e4.res));
                    end
                end
            end
        end
        check("lat4_ack_seen", 32'(got4), 32'd1);
        check("lat4_ack_delay", 32'(k4), 32'd6);
        check("lat4_ack_pulses", 32'(ack_cnt), 32'd1);
        check("lat4_busy_cycles", 32'(busy_cnt), 32'd6);
        check("lat4_ack0_quiet", 32'(other4), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
